booth_seq_multiplier: RTL

- Sequential signed radix-4 Booth multiplier.
- Contains the Booth encoder, the counterpart of the existing per-bit Booth decoder. Each cycle it scans one overlapping multiplier triplet, forms the digit {neg, two, one} and accumulates digit*x*4^i into a 2*WIDTH product.
- Used where area matters more than latency, e.g. the multi-cycle MUL path of the datapath.

---
 rtl/booth_seq_multiplier_if.sv | 23 ++
 rtl/booth_seq_multiplier.sv | 100 ++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier_if.sv
// Request/response bundle for the sequential radix-4 Booth multiplier.
// The requester (master) drives start/x/y; the multiplier (slave) returns status, digit and product.
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [2:0]             digit;

    modport master (
        output start, x, y,
        input  busy, done, product, digit
    );

    modport slave (
        input  start, x, y,
        output busy, done, product, digit
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential signed radix-4 Booth multiplier: one overlapping multiplier triplet per cycle.
// Optional early exit on an all-zero/all-one remaining multiplier: define BOOTH_SKIP_ZERO_EN.
module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_seq_multiplier_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int ITERS = WIDTH / 2;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;
    logic [WIDTH:0]  scan_q, scan_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            neg, one, two;
    logic [PW-1:0]   mag, addend, acc_next;
    logic [WIDTH:0]  scan_shift;
    logic            last, accept;

    // Booth encoder on the low triplet of the scan register; multiplicand is pre-shifted by 4^i.
    always_comb begin
        neg        = scan_q[2];
        one        = scan_q[1] ^ scan_q[0];
        two        = (scan_q[2] & ~scan_q[1] & ~scan_q[0]) | (~scan_q[2] & scan_q[1] & scan_q[0]);
        mag        = one ? mcand_q : (two ? {mcand_q[PW-2:0], 1'b0} : '0);
        addend     = neg ? (~mag + PW'(1)) : mag;
        acc_next   = acc_q + addend;
        scan_shift = {{2{scan_q[WIDTH]}}, scan_q[WIDTH:2]};
`ifdef BOOTH_SKIP_ZERO_EN
        // Sign-filled remainder that is uniform encodes only zero digits from here on.
        last = (cnt_q == CW'(ITERS - 1)) || (&scan_shift) || ~(|scan_shift);
`else
        last = (cnt_q == CW'(ITERS - 1));
`endif
    end

    assign accept = (state_q != RUN) && bus.start;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        scan_d    = scan_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                acc_d   = acc_next;
                scan_d  = scan_shift;
                mcand_d = {mcand_q[PW-3:0], 2'b00};
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    product_d = acc_next;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            mcand_d = {{WIDTH{bus.x[WIDTH-1]}}, bus.x};
            scan_d  = {bus.y, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            scan_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            scan_q    <= scan_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.digit   = (state_q == RUN) ? {neg, two, one} : 3'b000;
    assign bus.product = product_q;
endmodule
